xor4_bist_ctrl: RTL and testbench

Built-in self-test sequencer for the transistor-level 4-input dual-rail XOR cell (pins A/invA, B/invB, C/invC, D/invD, output).
- Replaces the hand-built clock-per-pin stimulus with one block that walks all 16 input combinations and drives both rails.
- Waits a programmable settle time per vector, then samples the cell output and compares it with expected parity.
- Reports pass/fail, an error count and the first failing vector; sits between the test-mode register bank and the cell under test.

---
 rtl/xor4_bist_pkg.sv | 18 +
 rtl/xor4_settle_timer.sv | 33 +++
 rtl/xor4_bist_ctrl.sv | 172 +++++++++++++++++
 tb/tb_xor4_bist_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/xor4_bist_pkg.sv
// Shared types and helpers for the 4-input dual-rail XOR cell self-test sequencer.
package xor4_bist_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int VEC_W = 4;
    localparam logic [VEC_W-1:0] LAST_VEC = 4'hF;

    function automatic logic parity4(input logic [VEC_W-1:0] vec, input logic pol);
        return (^vec) ^ pol;
    endfunction

endpackage

// File: rtl/xor4_settle_timer.sv
// 8-bit settle down-counter: load takes priority, en decrements until zero.
module xor4_settle_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       en,
    input  logic [7:0] load_val,
    output logic       zero
);

    logic [7:0] count_q;
    logic [7:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en && (count_q != 8'd0)) begin
            count_d = count_q - 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == 8'd0);

endmodule

// File: rtl/xor4_bist_ctrl.sv
// BIST sequencer: walks all 16 input vectors of the dual-rail XOR cell and checks its parity output.
module xor4_bist_ctrl
    import xor4_bist_pkg::*;
#(
    parameter int SETTLE_CYC = 4,
    parameter bit EXP_POL    = 1'b0,
    parameter int ERR_W      = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             dut_out,
    output logic             a,
    output logic             a_n,
    output logic             b,
    output logic             b_n,
    output logic             c,
    output logic             c_n,
    output logic             d,
    output logic             d_n,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             aborted,
    output logic [ERR_W-1:0] err_cnt,
    output logic [3:0]       first_fail_vec
);

    localparam logic [7:0]       SETTLE_LOAD = 8'(SETTLE_CYC - 1);
    localparam logic [ERR_W-1:0] ERR_MAX     = {ERR_W{1'b1}};

    state_t state_q, state_d;

    logic [VEC_W-1:0] vec_q, vec_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic [3:0]       first_fail_vec_q, first_fail_vec_d;
    logic             pass_q, pass_d;
    logic             aborted_q, aborted_d;

    logic timer_load;
    logic timer_en;
    logic timer_zero;

    xor4_settle_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .en       (timer_en),
        .load_val (SETTLE_LOAD),
        .zero     (timer_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = SETTLE;
            end
            SETTLE: begin
                if (abort)           state_d = IDLE;
                else if (timer_zero) state_d = SAMPLE;
            end
            SAMPLE: begin
                if (abort)                  state_d = IDLE;
                else if (vec_q == LAST_VEC) state_d = DONE;
                else                        state_d = SETTLE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == SETTLE) || (state_q == SAMPLE);
        done = (state_q == DONE);
    end

    // Run datapath; abort pre-empts any sample update or move to DONE.
    always_comb begin
        vec_d            = vec_q;
        err_cnt_d        = err_cnt_q;
        first_fail_vec_d = first_fail_vec_q;
        pass_d           = pass_q;
        aborted_d        = aborted_q;
        timer_load       = 1'b0;
        timer_en         = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    vec_d            = '0;
                    err_cnt_d        = '0;
                    first_fail_vec_d = '0;
                    pass_d           = 1'b0;
                    aborted_d        = 1'b0;
                    timer_load       = 1'b1;
                end
            end
            SETTLE: begin
                if (abort) begin
                    vec_d     = '0;
                    pass_d    = 1'b0;
                    aborted_d = 1'b1;
                end else begin
                    timer_en = 1'b1;
                end
            end
            SAMPLE: begin
                if (abort) begin
                    vec_d     = '0;
                    pass_d    = 1'b0;
                    aborted_d = 1'b1;
                end else begin
                    if (dut_out != parity4(vec_q, EXP_POL)) begin
                        if (err_cnt_q != ERR_MAX) err_cnt_d = err_cnt_q + 1'b1;
                        if (err_cnt_q == '0)      first_fail_vec_d = vec_q;
                    end
                    if (vec_q != LAST_VEC) begin
                        vec_d      = vec_q + 1'b1;
                        timer_load = 1'b1;
                    end
                end
            end
            DONE: begin
                pass_d = (err_cnt_q == '0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec_q            <= '0;
            err_cnt_q        <= '0;
            first_fail_vec_q <= '0;
            pass_q           <= 1'b0;
            aborted_q        <= 1'b0;
        end else begin
            vec_q            <= vec_d;
            err_cnt_q        <= err_cnt_d;
            first_fail_vec_q <= first_fail_vec_d;
            pass_q           <= pass_d;
            aborted_q        <= aborted_d;
        end
    end

    // Both rails of each pin come from the same vec_q bit, so they can never be equal.
    assign a   = vec_q[3];
    assign a_n = ~vec_q[3];
    assign b   = vec_q[2];
    assign b_n = ~vec_q[2];
    assign c   = vec_q[1];
    assign c_n = ~vec_q[1];
    assign d   = vec_q[0];
    assign d_n = ~vec_q[0];

    assign pass           = pass_q;
    assign aborted        = aborted_q;
    assign err_cnt        = err_cnt_q;
    assign first_fail_vec = first_fail_vec_q;

endmodule

// File: tb/tb_xor4_bist_ctrl.sv
// Directed bench for xor4_bist_ctrl: three configurations driven by behavioural cell models.
module tb_xor4_bist_ctrl;

    localparam int MODE_XOR   = 0;
    localparam int MODE_STUCK = 1;
    localparam int MODE_XNOR  = 2;

    typedef struct {
        int err;
        int ffv;
        int pass;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] start_v;
    logic       abort;
    logic [2:0] dut_out_v;
    logic [3:0] vec_v  [3];
    logic [3:0] vecn_v [3];
    logic [2:0] busy_v, done_v, pass_v, aborted_v;
    logic [4:0] err_v  [3];
    logic [3:0] ffv_v  [3];
    int         mode_v [3];

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    function automatic logic cell_out(input int mode, input logic [3:0] v);
        case (mode)
            MODE_STUCK: return 1'b0;
            MODE_XNOR:  return ~(v[3] ^ v[2] ^ v[1] ^ v[0]);
            default:    return v[3] ^ v[2] ^ v[1] ^ v[0];
        endcase
    endfunction

    function automatic int settle_of(input int idx);
        return (idx == 2) ? 1 : 4;
    endfunction

    function automatic int pol_of(input int idx);
        return (idx == 1) ? 1 : 0;
    endfunction

    // Expected outcome after the first nvec vectors have been sampled.
    function automatic exp_t expect_run(input int mode, input int pol, input int nvec);
        exp_t r;
        logic [3:0] v;
        logic e;
        r.err = 0;
        r.ffv = 0;
        for (int k = 0; k < nvec; k++) begin
            v = 4'(k);
            e = v[3] ^ v[2] ^ v[1] ^ v[0] ^ pol[0];
            if (cell_out(mode, v) != e) begin
                if (r.err == 0) r.ffv = k;
                r.err++;
            end
        end
        r.pass = (r.err == 0) ? 1 : 0;
        return r;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        assign dut_out_v[g] = cell_out(mode_v[g], vec_v[g]);
        xor4_bist_ctrl #(
            .SETTLE_CYC (settle_of(g)),
            .EXP_POL    (pol_of(g) != 0),
            .ERR_W      (5)
        ) u_dut (
            .clk            (clk),
            .rst            (rst),
            .start          (start_v[g]),
            .abort          (abort),
            .dut_out        (dut_out_v[g]),
            .a              (vec_v[g][3]),
            .a_n            (vecn_v[g][3]),
            .b              (vec_v[g][2]),
            .b_n            (vecn_v[g][2]),
            .c              (vec_v[g][1]),
            .c_n            (vecn_v[g][1]),
            .d              (vec_v[g][0]),
            .d_n            (vecn_v[g][0]),
            .busy           (busy_v[g]),
            .done           (done_v[g]),
            .pass           (pass_v[g]),
            .aborted        (aborted_v[g]),
            .err_cnt        (err_v[g]),
            .first_fail_vec (ffv_v[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            assert (vecn_v[i] === ~vec_v[i]) else begin
                n_err++;
                $error("FAIL rails%0d observed=%0h expected=%0h", i, vecn_v[i], ~vec_v[i]);
            end
        end
    end

    task automatic check_reset(input int idx);
        check($sformatf("rst_vec%0d", idx),  32'(vec_v[idx]),  32'h0);
        check($sformatf("rst_vecn%0d", idx), 32'(vecn_v[idx]), 32'hF);
        check($sformatf("rst_busy%0d", idx), 32'(busy_v[idx]), 32'h0);
        check($sformatf("rst_done%0d", idx), 32'(done_v[idx]), 32'h0);
        check($sformatf("rst_pass%0d", idx), 32'(pass_v[idx]), 32'h0);
        check($sformatf("rst_abrt%0d", idx), 32'(aborted_v[idx]), 32'h0);
        check($sformatf("rst_err%0d", idx),  32'(err_v[idx]),  32'h0);
        check($sformatf("rst_ffv%0d", idx),  32'(ffv_v[idx]),  32'h0);
    endtask

    // Start a run on instance idx; cycle k is the interval after edge k-1, start sampled at edge 0.
    task automatic run(input string tag, input int idx, input int mode,
                       input int abort_cyc, input int restart_cyc);
        int   s;
        int   exp_done;
        int   max_cyc;
        int   done_cnt;
        int   done_at;
        int   busy_cnt;
        int   nvec;
        exp_t e;
        exp_t got;
        s        = settle_of(idx);
        exp_done = 16 * (s + 1) + 1;
        max_cyc  = (abort_cyc > 0) ? exp_done + 9 : exp_done + 2;
        done_cnt = 0;
        done_at  = 0;
        busy_cnt = 0;
        got      = '{err: -1, ffv: -1, pass: -1};
        mode_v[idx] = mode;
        if (abort_cyc == 0) sb.push_back(expect_run(mode, pol_of(idx), 16));
        @(negedge clk);
        start_v[idx] = 1'b1;
        @(posedge clk);
        #1;
        start_v[idx] = 1'b0;
        for (int k = 1; k <= max_cyc; k++) begin
            abort        = (k == abort_cyc);
            start_v[idx] = (k == restart_cyc);
            if (k == 1) begin
                check({tag, "_c1_err"},  32'(err_v[idx]), 32'h0);
                check({tag, "_c1_abrt"}, 32'(aborted_v[idx]), 32'h0);
                check({tag, "_c1_busy"}, 32'(busy_v[idx]), 32'h1);
            end
            if (abort_cyc > 0 && k == abort_cyc + 1)
                check({tag, "_busy_after_abort"}, 32'(busy_v[idx]), 32'h0);
            if (busy_v[idx]) busy_cnt++;
            if (done_v[idx]) begin
                done_cnt++;
                done_at = k;
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    got.err = int'(err_v[idx]);
                    got.ffv = int'(ffv_v[idx]);
                end
            end
            @(posedge clk);
            #1;
        end
        abort        = 1'b0;
        start_v[idx] = 1'b0;
        if (abort_cyc == 0) begin
            check({tag, "_done_cnt"}, 32'(done_cnt), 32'h1);
            check({tag, "_done_at"},  32'(done_at),  32'(exp_done));
            check({tag, "_busy_cnt"}, 32'(busy_cnt), 32'(exp_done - 1));
            if (done_cnt == 0 && sb.size() > 0) e = sb.pop_front();
            check({tag, "_err"},  32'(got.err), 32'(e.err));
            check({tag, "_ffv"},  32'(got.ffv), 32'(e.ffv));
            check({tag, "_pass"}, 32'(pass_v[idx]), 32'(e.pass));
            check({tag, "_abrt"}, 32'(aborted_v[idx]), 32'h0);
            check({tag, "_vec_hold"}, 32'(vec_v[idx]), 32'hF);
        end else begin
            nvec = 0;
            for (int k = 0; k < 16; k++)
                if ((k + 1) * (s + 1) < abort_cyc) nvec++;
            e = expect_run(mode, pol_of(idx), nvec);
            check({tag, "_done_cnt"}, 32'(done_cnt), 32'h0);
            check({tag, "_abrt"}, 32'(aborted_v[idx]), 32'h1);
            check({tag, "_pass"}, 32'(pass_v[idx]), 32'h0);
            check({tag, "_err"},  32'(err_v[idx]), 32'(e.err));
            check({tag, "_ffv"},  32'(ffv_v[idx]), 32'(e.ffv));
            check({tag, "_vec"},  32'(vec_v[idx]), 32'h0);
            check({tag, "_busy"}, 32'(busy_v[idx]), 32'h0);
        end
    endtask

    initial begin
        int dcnt;
        rst     = 1'b1;
        start_v = '0;
        abort   = 1'b0;
        for (int i = 0; i < 3; i++) mode_v[i] = MODE_XOR;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) check_reset(i);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        run("xor_ok",     0, MODE_XOR,   0, 0);
        run("stuck0",     0, MODE_STUCK, 0, 0);
        run("xnor_pol0",  0, MODE_XNOR,  0, 0);
        run("xnor_pol1",  1, MODE_XNOR,  0, 0);
        run("abort30",    0, MODE_STUCK, 30, 0);
        run("restart40",  0, MODE_XOR,   0, 40);
        run("after_done", 0, MODE_STUCK, 0, 0);

        // Reset pulsed between edges in cycle 50 of a run.
        mode_v[0] = MODE_STUCK;
        dcnt = 0;
        @(negedge clk);
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        for (int k = 1; k < 50; k++) begin
            if (done_v[0]) dcnt++;
            @(posedge clk);
            #1;
        end
        check("mid_busy", 32'(busy_v[0]), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check_reset(0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (done_v[0]) dcnt++;
        end
        check("mid_rst_no_done", 32'(dcnt), 32'h0);
        check_reset(0);

        run("fast_s1", 2, MODE_XOR, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
